// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared FSM codes, widths and request record for dmem_responder
package dmem_responder_pkg;

  localparam int DMEM_STATE_LENGTH = 2;
  localparam int DMEM_LAT_WIDTH    = 4;

  localparam logic [DMEM_STATE_LENGTH-1:0] DMEM_IDLE = 2'd0;
  localparam logic [DMEM_STATE_LENGTH-1:0] DMEM_WAIT = 2'd1;
  localparam logic [DMEM_STATE_LENGTH-1:0] DMEM_RESP = 2'd2;

  // One latched load/store request as seen at the handshake edge.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

endpackage

// File: rtl/dmem_byte_ram.sv
// rtl/dmem_byte_ram.sv - word array with per-byte write enables and registered read
module dmem_byte_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [3:0]            we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // Byte-lane writes and the read register share one edge; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked slow data memory for the load/store port (option: DMEM_ALIGN_CHECK_EN)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [DMEM_LAT_WIDTH-1:0] LAT = LATENCY[DMEM_LAT_WIDTH-1:0];

  logic [DMEM_STATE_LENGTH-1:0] state_q, state_d;
  logic [DMEM_LAT_WIDTH-1:0]    cnt_q, cnt_d;
  dmem_req_t                    req_q, req_d;
  logic                         resp_err_q, resp_err_d;
  logic                         load_ok_q, load_ok_d;

  dmem_req_t   req_in;
  dmem_req_t   cur;
  logic        handshake;
  logic        commit;
  logic        range_err;
  logic        align_err;
  logic        err;
  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;
  logic [1:0]  unused_addr_bits;

  assign req_ready = (state_q == DMEM_IDLE) && !rst;
  assign handshake = req_valid && req_ready;

  assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

  // With zero latency the commit edge is the handshake edge, so the live inputs are used.
  assign cur = (state_q == DMEM_IDLE) ? req_in : req_q;

  assign commit = !rst && (((LATENCY == 0) && handshake) ||
                           ((state_q == DMEM_WAIT) && (cnt_q <= 4'd1)));

  assign range_err = (cur.addr[31:ADDR_WIDTH+2] != '0);

`ifdef DMEM_ALIGN_CHECK_EN
  // Word accesses need a word boundary, half-word-shaped stores a half-word boundary.
  always_comb begin
    align_err = 1'b0;
    if (!cur.we) begin
      align_err = (cur.addr[1:0] != 2'b00);
    end else if (cur.be == 4'b1111) begin
      align_err = (cur.addr[1:0] != 2'b00);
    end else if ((cur.be == 4'b0011) || (cur.be == 4'b1100)) begin
      align_err = cur.addr[0];
    end
  end
`else
  assign align_err = 1'b0;
`endif

  assign unused_addr_bits = cur.addr[1:0];

  assign err = range_err || align_err;

  assign ram_we = (commit && cur.we && !err) ? cur.be : 4'b0000;
  assign ram_re = commit && !cur.we;

  dmem_byte_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (cur.addr[ADDR_WIDTH+1:2]),
    .wdata_i (cur.wdata),
    .rdata_o (ram_rdata)
  );

  // Next-state logic for the IDLE/WAIT/RESP sequencer and the response flags.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    resp_err_d = resp_err_q;
    load_ok_d  = load_ok_q;
    case (state_q)
      DMEM_IDLE: begin
        if (handshake) begin
          req_d   = req_in;
          cnt_d   = LAT;
          state_d = (LATENCY == 0) ? DMEM_RESP : DMEM_WAIT;
        end
      end
      DMEM_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = DMEM_RESP;
        end
      end
      DMEM_RESP: begin
        state_d    = DMEM_IDLE;
        resp_err_d = 1'b0;
        load_ok_d  = 1'b0;
      end
      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
    if (commit) begin
      resp_err_d = err;
      load_ok_d  = !cur.we && !err;
    end
  end

  // State registers; reset drops any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DMEM_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      resp_err_q <= 1'b0;
      load_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      resp_err_q <= resp_err_d;
      load_ok_q  <= load_ok_d;
    end
  end

  assign resp_valid = (state_q == DMEM_RESP);
  assign resp_err   = resp_err_q;
  assign resp_rdata = load_ok_q ? ram_rdata : 32'h0;

endmodule
